// File: rtl/axis_packet_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axis_packet_checker
// Purpose  : AXI-Stream traffic sink that checks multi-flit packets and keeps
//            statistics. Latency stats built only with AXIS_CHECKER_LATENCY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_packet_checker #(
  parameter int          TDATA_WIDTH   = 512,
  parameter int          TID_WIDTH     = 2,
  parameter int          TDEST_WIDTH   = 2,
  parameter int          NUM_SOURCES   = 4,
  parameter int          TDEST         = 0,
  parameter int          COUNT_WIDTH   = 32,
  parameter int          TICK_WIDTH    = 32,
  parameter int          PKT_FLITS     = 4,
  parameter int          BP_MODE       = 0,
  parameter int          BP_READY_256  = 192,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          LAT_SUM_WIDTH = 48
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [TICK_WIDTH-1:0]                   ticks,
  input  logic                                    axis_in_tvalid,
  output logic                                    axis_in_tready,
  input  logic [TDATA_WIDTH-1:0]                  axis_in_tdata,
  input  logic                                    axis_in_tlast,
  input  logic [TID_WIDTH-1:0]                    axis_in_tid,
  input  logic [TDEST_WIDTH-1:0]                  axis_in_tdest,
  output logic [NUM_SOURCES-1:0][COUNT_WIDTH-1:0] recv_packets,
  output logic [COUNT_WIDTH-1:0]                  total_recv_packets,
  output logic [COUNT_WIDTH-1:0]                  total_recv_flits,
  output logic                                    error,
  output logic [2:0]                              error_code,
  output logic [COUNT_WIDTH-1:0]                  error_count,
  output logic [TICK_WIDTH-1:0]                   lat_min,
  output logic [TICK_WIDTH-1:0]                   lat_max,
  output logic [LAT_SUM_WIDTH-1:0]                lat_sum,
  output logic [TICK_WIDTH-1:0]                   first_tick,
  output logic [TICK_WIDTH-1:0]                   last_tick
);

  localparam int                     IDX_W        = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(PKT_FLITS - 1);
  localparam bit                     SINGLE_FLIT  = (PKT_FLITS == 1);
  localparam logic [TDEST_WIDTH-1:0] MY_TDEST     = TDEST_WIDTH'(TDEST);
  localparam logic [8:0]             BP_THRESHOLD = 9'(BP_READY_256);
  localparam logic [15:0]            LFSR_INIT    = LFSR_SEED ^ 16'(TDEST);
  localparam logic [15:0]            LFSR_TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    ST_HEAD  = 2'd0,
    ST_BODY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                                  state_q, state_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic [TID_WIDTH-1:0]                    tid_q, tid_d;
  logic [COUNT_WIDTH-1:0]                  seq_q, seq_d;
  logic [NUM_SOURCES-1:0][COUNT_WIDTH-1:0] recv_q;
  logic [COUNT_WIDTH-1:0]                  tot_pkts_q, tot_flits_q, err_cnt_q;
  logic                                    err_q;
  logic [2:0]                              err_code_q;
  logic                                    tready_q;

  logic                   hs, tid_valid, tdest_ok;
  logic                   is_header, pkt_end, complete;
  logic [2:0]             err_now;
  logic [TID_WIDTH-1:0]   done_tid;
  logic [COUNT_WIDTH-1:0] done_seq, flit_seq, exp_seq;

  assign hs        = axis_in_tvalid & tready_q;
  assign flit_seq  = axis_in_tdata[COUNT_WIDTH-1:0];
  assign tid_valid = int'(axis_in_tid) < NUM_SOURCES;
  assign tdest_ok  = (axis_in_tdest == MY_TDEST);

  always_comb begin
    exp_seq = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (int'(axis_in_tid) == s) exp_seq = recv_q[s];
    end
  end

  // Error priority chains list codes in ascending order so the lowest wins.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tid_d     = tid_q;
    seq_d     = seq_q;
    err_now   = 3'd0;
    is_header = 1'b0;
    pkt_end   = 1'b0;
    complete  = 1'b0;
    done_tid  = tid_q;
    done_seq  = seq_q;
    if (hs) begin
      unique case (state_q)
        ST_HEAD: begin
          is_header = 1'b1;
          pkt_end   = axis_in_tlast;
          tid_d     = axis_in_tid;
          seq_d     = flit_seq;
          idx_d     = IDX_W'(1);
          done_tid  = axis_in_tid;
          done_seq  = flit_seq;
          if (tid_valid && (flit_seq != exp_seq))         err_now = 3'd1;
          else if (!tdest_ok)                             err_now = 3'd2;
          else if (!SINGLE_FLIT && axis_in_tlast)         err_now = 3'd3;
          else if (SINGLE_FLIT && !axis_in_tlast)         err_now = 3'd4;
          else if (!tid_valid)                            err_now = 3'd7;
          if (axis_in_tlast) begin
            complete = tid_valid;
            state_d  = ST_HEAD;
          end else if (!tid_valid || SINGLE_FLIT) begin
            state_d  = ST_DRAIN;
          end else begin
            state_d  = ST_BODY;
          end
        end
        ST_BODY: begin
          pkt_end = axis_in_tlast;
          idx_d   = idx_q + IDX_W'(1);
          if (!tdest_ok)                                          err_now = 3'd2;
          else if (axis_in_tlast && (idx_q != LAST_IDX))          err_now = 3'd3;
          else if (!axis_in_tlast && (idx_q == LAST_IDX))         err_now = 3'd4;
          else if (axis_in_tid != tid_q)                          err_now = 3'd5;
          else if (flit_seq != (seq_q ^ COUNT_WIDTH'(idx_q)))     err_now = 3'd6;
          else if (!tid_valid)                                    err_now = 3'd7;
          if (axis_in_tlast) begin
            complete = tid_valid;
            state_d  = ST_HEAD;
          end else if ((idx_q == LAST_IDX) || !tid_valid) begin
            state_d  = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (axis_in_tlast) state_d = ST_HEAD;
        end
        default: state_d = ST_HEAD;
      endcase
    end
  end

  // Storing seq+1 both counts normally and resyncs after a sequence gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HEAD;
      idx_q       <= '0;
      tid_q       <= '0;
      seq_q       <= '0;
      recv_q      <= '0;
      tot_pkts_q  <= '0;
      tot_flits_q <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tid_q   <= tid_d;
      seq_q   <= seq_d;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        if (complete && (int'(done_tid) == s)) recv_q[s] <= done_seq + COUNT_WIDTH'(1);
      end
      if (pkt_end) tot_pkts_q  <= tot_pkts_q + COUNT_WIDTH'(1);
      if (hs)      tot_flits_q <= tot_flits_q + COUNT_WIDTH'(1);
      if (err_now != 3'd0) begin
        err_q <= 1'b1;
        if (!err_q)           err_code_q <= err_now;
        if (err_cnt_q != '1)  err_cnt_q  <= err_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  generate
    if (BP_MODE == 1) begin : g_bp_lfsr
      logic [15:0] lfsr_q, lfsr_d;
      assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      always_ff @(posedge clk) begin
        if (rst) begin
          lfsr_q   <= LFSR_INIT;
          tready_q <= 1'b0;
        end else begin
          lfsr_q   <= lfsr_d;
          tready_q <= ({1'b0, lfsr_d[7:0]} < BP_THRESHOLD);
        end
      end
    end else begin : g_bp_none
      always_ff @(posedge clk) begin
        tready_q <= ~rst;
      end
    end
  endgenerate

`ifdef AXIS_CHECKER_LATENCY_EN
  logic [TICK_WIDTH-1:0]    lat_min_q, lat_max_q, first_q, last_q, lat_now;
  logic [LAT_SUM_WIDTH-1:0] lat_sum_q;
  logic [LAT_SUM_WIDTH:0]   sum_ext;
  logic                     seen_q;

  assign lat_now = ticks - axis_in_tdata[TDATA_WIDTH-1 -: TICK_WIDTH];
  assign sum_ext = {1'b0, lat_sum_q} + {{(LAT_SUM_WIDTH + 1 - TICK_WIDTH){1'b0}}, lat_now};

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_min_q <= '1;
      lat_max_q <= '0;
      lat_sum_q <= '0;
      first_q   <= '0;
      last_q    <= '0;
      seen_q    <= 1'b0;
    end else begin
      if (is_header) begin
        if (lat_now < lat_min_q) lat_min_q <= lat_now;
        if (lat_now > lat_max_q) lat_max_q <= lat_now;
        lat_sum_q <= sum_ext[LAT_SUM_WIDTH] ? '1 : sum_ext[LAT_SUM_WIDTH-1:0];
      end
      if (hs) begin
        last_q <= ticks;
        if (!seen_q) begin
          first_q <= ticks;
          seen_q  <= 1'b1;
        end
      end
    end
  end

  assign lat_min    = lat_min_q;
  assign lat_max    = lat_max_q;
  assign lat_sum    = lat_sum_q;
  assign first_tick = first_q;
  assign last_tick  = last_q;
`else
  assign lat_min    = '1;
  assign lat_max    = '0;
  assign lat_sum    = '0;
  assign first_tick = '0;
  assign last_tick  = '0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{axis_in_tdata, ticks, is_header};

  assign axis_in_tready     = tready_q;
  assign recv_packets       = recv_q;
  assign total_recv_packets = tot_pkts_q;
  assign total_recv_flits   = tot_flits_q;
  assign error              = err_q;
  assign error_code         = err_code_q;
  assign error_count        = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_packet_checker
// Purpose  : Directed self-checking bench for axis_packet_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_packet_checker;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      ticks = 32'd0;
  logic             tvalid = 1'b0, tready, tlast = 1'b0;
  logic [63:0]      tdata = 64'd0;
  logic [1:0]       tid = 2'd0, tdest = 2'd0;
  logic [2:0][31:0] recv_packets;
  logic [31:0]      total_pkts, total_flits, err_count;
  logic             error;
  logic [2:0]       err_code;
  logic [31:0]      lat_min, lat_max, first_tick, last_tick;
  logic [47:0]      lat_sum;

  logic             bp_rst = 1'b1, bp_tvalid = 1'b0, bp_tready;
  logic [2:0][31:0] bp_recv;
  logic [31:0]      bp_pkts, bp_flits, bp_ecnt, bp_lmin, bp_lmax, bp_first, bp_last;
  logic             bp_err;
  logic [2:0]       bp_ecode;
  logic [47:0]      bp_lsum;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axis_packet_checker #(
    .TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(2), .NUM_SOURCES(3), .TDEST(0),
    .COUNT_WIDTH(32), .TICK_WIDTH(32), .PKT_FLITS(4), .BP_MODE(0),
    .BP_READY_256(192), .LFSR_SEED(16'hACE1), .LAT_SUM_WIDTH(48)
  ) u_dut (
    .clk(clk), .rst(rst), .ticks(ticks),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
    .recv_packets(recv_packets), .total_recv_packets(total_pkts),
    .total_recv_flits(total_flits), .error(error), .error_code(err_code),
    .error_count(err_count), .lat_min(lat_min), .lat_max(lat_max),
    .lat_sum(lat_sum), .first_tick(first_tick), .last_tick(last_tick)
  );

  axis_packet_checker #(
    .TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(2), .NUM_SOURCES(3), .TDEST(0),
    .COUNT_WIDTH(32), .TICK_WIDTH(32), .PKT_FLITS(4), .BP_MODE(1),
    .BP_READY_256(64), .LFSR_SEED(16'hACE1), .LAT_SUM_WIDTH(48)
  ) u_bp (
    .clk(clk), .rst(bp_rst), .ticks(32'd0),
    .axis_in_tvalid(bp_tvalid), .axis_in_tready(bp_tready), .axis_in_tdata(64'd0),
    .axis_in_tlast(1'b0), .axis_in_tid(2'd0), .axis_in_tdest(2'd0),
    .recv_packets(bp_recv), .total_recv_packets(bp_pkts),
    .total_recv_flits(bp_flits), .error(bp_err), .error_code(bp_ecode),
    .error_count(bp_ecnt), .lat_min(bp_lmin), .lat_max(bp_lmax),
    .lat_sum(bp_lsum), .first_tick(bp_first), .last_tick(bp_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic [1:0] id, input logic [1:0] dst,
                      input logic [63:0] d, input logic l);
    int guard;
    tvalid = 1'b1; tid = id; tdest = dst; tdata = d; tlast = l;
    guard = 0;
    while (!tready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) check("tready_wait", {63'd0, tready}, 64'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] id, input logic [31:0] seq, input logic [31:0] sent);
    send(id, 2'd0, {sent, seq}, 1'b0);
    for (int k = 1; k < 4; k++) send(id, 2'd0, {32'd0, seq ^ 32'(k)}, (k == 3));
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt1, cnt2;
    logic [31:0] sig1, sig2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tready", {63'd0, tready}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_flits", total_flits, 64'd0);
    check("rst_lat_min", lat_min, 64'hFFFF_FFFF);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_rst", {63'd0, tready}, 64'd1);

    // Three clean packets from tid 1
    send_pkt(2'd1, 32'd0, 32'd0);
    send_pkt(2'd1, 32'd1, 32'd0);
    send_pkt(2'd1, 32'd2, 32'd0);
    check("t1_recv1", recv_packets[1], 64'd3);
    check("t1_flits", total_flits, 64'd12);
    check("t1_pkts", total_pkts, 64'd3);
    check("t1_error", {63'd0, error}, 64'd0);

    // Sequence gap on tid 0: 0, 2, 3
    send_pkt(2'd0, 32'd0, 32'd0);
    send_pkt(2'd0, 32'd2, 32'd0);
    check("t2_error", {63'd0, error}, 64'd1);
    check("t2_code", {61'd0, err_code}, 64'd1);
    check("t2_count", err_count, 64'd1);
    check("t2_recv0", recv_packets[0], 64'd3);
    send_pkt(2'd0, 32'd3, 32'd0);
    check("t2_count_resync", err_count, 64'd1);
    check("t2_pkts", total_pkts, 64'd6);

    // Missing tlast on flit 4, two extra flits drained, then a good packet
    do_reset();
    send(2'd2, 2'd0, 64'd0, 1'b0);
    for (int k = 1; k < 4; k++) send(2'd2, 2'd0, {32'd0, 32'(k)}, 1'b0);
    send(2'd2, 2'd0, 64'hDEAD, 1'b0);
    send(2'd2, 2'd0, 64'hBEEF, 1'b1);
    idle();
    check("t3_code", {61'd0, err_code}, 64'd4);
    check("t3_count", err_count, 64'd1);
    check("t3_pkts", total_pkts, 64'd0);
    check("t3_recv2_bad", recv_packets[2], 64'd0);
    send_pkt(2'd2, 32'd0, 32'd0);
    check("t3_count_after", err_count, 64'd1);
    check("t3_recv2", recv_packets[2], 64'd1);
    check("t3_flits", total_flits, 64'd10);

    // Reset on flit 2 of a packet, then a fresh packet with seq 0
    send(2'd1, 2'd0, 64'd0, 1'b0);
    tdata = {32'd0, 32'd1};
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    send_pkt(2'd1, 32'd0, 32'd0);
    check("t4_error", {63'd0, error}, 64'd0);
    check("t4_recv1", recv_packets[1], 64'd1);
    check("t4_recv2", recv_packets[2], 64'd0);
    check("t4_flits", total_flits, 64'd4);

    // Header latency, including tick wrap-around
    do_reset();
    ticks = 32'd130;
    send_pkt(2'd0, 32'd0, 32'd100);
`ifdef AXIS_CHECKER_LATENCY_EN
    check("lat_min_1", lat_min, 64'd30);
    check("lat_max_1", lat_max, 64'd30);
`else
    check("lat_min_1", lat_min, 64'hFFFF_FFFF);
    check("lat_max_1", lat_max, 64'd0);
`endif
    ticks = 32'h10;
    send_pkt(2'd0, 32'd1, 32'hFFFF_FFF0);
`ifdef AXIS_CHECKER_LATENCY_EN
    check("lat_min", lat_min, 64'd30);
    check("lat_max", lat_max, 64'd32);
    check("lat_sum", lat_sum, 64'd62);
    check("first_tick", first_tick, 64'd130);
    check("last_tick", last_tick, 64'h10);
`else
    check("lat_min", lat_min, 64'hFFFF_FFFF);
    check("lat_max", lat_max, 64'd0);
    check("lat_sum", lat_sum, 64'd0);
    check("first_tick", first_tick, 64'd0);
    check("last_tick", last_tick, 64'd0);
`endif
    check("lat_error", {63'd0, error}, 64'd0);

    // Wrong tdest on header
    send(2'd1, 2'd1, {32'h10, 32'd0}, 1'b0);
    for (int k = 1; k < 4; k++) send(2'd1, 2'd0, {32'd0, 32'(k)}, (k == 3));
    idle();
    check("c2_code", {61'd0, err_code}, 64'd2);
    check("c2_count", err_count, 64'd1);
    check("c2_recv1", recv_packets[1], 64'd1);

    // Corrupted body pattern
    send(2'd1, 2'd0, {32'h10, 32'd1}, 1'b0);
    send(2'd1, 2'd0, {32'd0, 32'h0000_00FF}, 1'b0);
    send(2'd1, 2'd0, {32'd0, 32'd3}, 1'b0);
    send(2'd1, 2'd0, {32'd0, 32'd2}, 1'b1);
    idle();
    check("c6_count", err_count, 64'd2);
    check("c6_code_sticky", {61'd0, err_code}, 64'd2);

    // Early tlast still completes the packet
    send(2'd1, 2'd0, {32'h10, 32'd2}, 1'b0);
    send(2'd1, 2'd0, {32'd0, 32'd3}, 1'b1);
    idle();
    check("c3_count", err_count, 64'd3);
    check("c3_recv1", recv_packets[1], 64'd3);
    check("c3_pkts", total_pkts, 64'd5);

    // tid changes mid-packet
    send(2'd1, 2'd0, {32'h10, 32'd3}, 1'b0);
    send(2'd1, 2'd0, {32'd0, 32'd2}, 1'b0);
    send(2'd2, 2'd0, {32'd0, 32'd1}, 1'b0);
    send(2'd1, 2'd0, {32'd0, 32'd0}, 1'b1);
    idle();
    check("c5_count", err_count, 64'd4);
    check("c5_recv1", recv_packets[1], 64'd4);
    check("c5_recv2", recv_packets[2], 64'd0);

    // Out-of-range tid: drained, no packet counted
    send(2'd3, 2'd0, {32'h10, 32'd0}, 1'b0);
    for (int k = 1; k < 4; k++) send(2'd3, 2'd0, {32'd0, 32'(k)}, (k == 3));
    idle();
    check("c7_count", err_count, 64'd5);
    check("c7_pkts", total_pkts, 64'd6);
    check("c7_flits", total_flits, 64'd26);
    send_pkt(2'd0, 32'd2, 32'h10);
    check("c7_good_count", err_count, 64'd5);
    check("c7_recv0", recv_packets[0], 64'd3);
    check("c7_good_pkts", total_pkts, 64'd7);

    // LFSR backpressure, two identical runs
    check("bp_rst_tready", {63'd0, bp_tready}, 64'd0);
    bp_rst = 1'b0;
    bp_tvalid = 1'b1;
    cnt1 = 0; sig1 = 32'd0;
    for (int i = 0; i < 4096; i++) begin
      if (bp_tready) cnt1++;
      sig1 = (sig1 * 32'd31) + {31'd0, bp_tready};
      @(negedge clk);
    end
    bp_tvalid = 1'b0;
    check("bp_flits_run1", bp_flits, 64'(cnt1));
    check("bp_rate_in_range", {63'd0, (cnt1 >= 922) && (cnt1 <= 1126)}, 64'd1);
    bp_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_rst2_tready", {63'd0, bp_tready}, 64'd0);
    bp_rst = 1'b0;
    bp_tvalid = 1'b1;
    cnt2 = 0; sig2 = 32'd0;
    for (int i = 0; i < 4096; i++) begin
      if (bp_tready) cnt2++;
      sig2 = (sig2 * 32'd31) + {31'd0, bp_tready};
      @(negedge clk);
    end
    bp_tvalid = 1'b0;
    check("bp_count_repeat", 64'(cnt2), 64'(cnt1));
    check("bp_pattern_repeat", {32'd0, sig2}, {32'd0, sig1});
    check("bp_flits_run2", bp_flits, 64'(cnt2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
